// File: rtl/conv_window_sequencer_pkg.sv
// Shared types and width helpers for the conv window sequencer.
// Defaults match one 32x32 feature map with a 3x3 kernel.
package conv_window_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int IFM_SIZE_DEF     = 32;
  localparam int KERNEL_SIZE_DEF  = 3;
  localparam int PIPE_LATENCY_DEF = 8;

  function automatic int cnt_width(int ifm);
    return $clog2(ifm);
  endfunction

  function automatic int win_count(int ifm, int k);
    return (ifm - k + 1) * (ifm - k + 1);
  endfunction

  function automatic int out_width(int ifm, int k);
    return $clog2(win_count(ifm, k) + 1);
  endfunction

endpackage

// File: rtl/conv_window_sequencer_valid_delay_line.sv
// Fixed-depth 1-bit shift register that tracks window-valid flags
// alongside the conv datapath.
module conv_window_sequencer_valid_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= d_i;
    end
  end else begin : g_many
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// Raster-order pixel sequencer for one conv unit: pops pixels,
// flags complete windows and aligns them to the datapath output.
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int IFM_SIZE     = IFM_SIZE_DEF,
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
  parameter int CNT_W        = cnt_width(IFM_SIZE),
  parameter int OUT_W        = out_width(IFM_SIZE, KERNEL_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_ready,
  output logic             rd_en,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] col_cnt,
  output logic             win_valid,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_cnt,
  output logic             busy,
  output logic             done
);

  localparam int DW = $clog2(PIPE_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IFM_SIZE - 1);
  localparam logic [CNT_W-1:0] KM1  = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [DW-1:0]    LATC = DW'(PIPE_LATENCY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [OUT_W-1:0] outc_q, outc_d;
  logic             win_q, win_d;
  logic             rd;
  logic             ov;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    outc_d  = outc_q;
    rd      = 1'b0;
    if (ov) outc_d = outc_q + OUT_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          drain_d = '0;
          outc_d  = '0;
        end
      end
      S_RUN: begin
        rd = in_ready;
        if (rd) begin
          if (col_q == LAST) begin
            col_d = '0;
            if (row_q == LAST) begin
              row_d   = '0;
              drain_d = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == LATC) state_d = S_DONE;
        else drain_d = drain_q + DW'(1);
      end
      S_DONE: state_d = S_IDLE;
    endcase
  end

  // Bubbles enter the pipe as zeros; the datapath never stalls.
  assign win_d = rd && (row_q >= KM1) && (col_q >= KM1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      outc_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      outc_q  <= outc_d;
      win_q   <= win_d;
    end
  end

  conv_window_sequencer_valid_delay_line #(
    .DEPTH(PIPE_LATENCY)
  ) u_dly (
    .clk_i (clk),
    .rst_ni(reset),
    .d_i   (win_q),
    .q_o   (ov)
  );

  assign rd_en     = rd;
  assign row_cnt   = row_q;
  assign col_cnt   = col_q;
  assign win_valid = win_q;
  assign out_valid = ov;
  assign out_cnt   = outc_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomized bench for conv_window_sequencer against a cycle-list
// reference model derived from the raster/window/latency rules.
module tb_conv_window_sequencer;

  localparam int K    = 3;
  localparam int LAT  = 8;
  localparam int SI   = 4;
  localparam int BI   = 32;
  localparam int MAXC = 1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_start = 1'b0, s_ready = 1'b0;
  logic b_start = 1'b0, b_ready = 1'b0;

  logic       s_rd, s_win, s_ov, s_busy, s_done;
  logic [1:0] s_row, s_col;
  logic [2:0] s_oc;
  logic       b_rd, b_win, b_ov, b_busy, b_done;
  logic [4:0] b_row, b_col;
  logic [9:0] b_oc;

  int n_chk = 0;
  int n_err = 0;

  bit ir     [MAXC];
  bit e_rd   [MAXC];
  bit e_win  [MAXC];
  bit e_out  [MAXC];
  bit e_busy [MAXC];
  int e_row  [MAXC];
  int e_col  [MAXC];

  always #5 clk = ~clk;

  conv_window_sequencer #(
    .IFM_SIZE(SI), .KERNEL_SIZE(K), .PIPE_LATENCY(LAT)
  ) u_small (
    .clk(clk), .reset(rst_n), .start(s_start), .in_ready(s_ready),
    .rd_en(s_rd), .row_cnt(s_row), .col_cnt(s_col),
    .win_valid(s_win), .out_valid(s_ov), .out_cnt(s_oc),
    .busy(s_busy), .done(s_done)
  );

  conv_window_sequencer u_big (
    .clk(clk), .reset(rst_n), .start(b_start), .in_ready(b_ready),
    .rd_en(b_rd), .row_cnt(b_row), .col_cnt(b_col),
    .win_valid(b_win), .out_valid(b_ov), .out_cnt(b_oc),
    .busy(b_busy), .done(b_done)
  );

  task automatic check(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle in which start is sampled in IDLE.
  task automatic build(int ifm, output int dcyc);
    int n, t, l;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_win[i] = 0; e_out[i] = 0; e_busy[i] = 0;
      e_row[i] = 0; e_col[i] = 0;
    end
    n = 0; t = 1; l = 0;
    while (n < ifm * ifm) begin
      if (ir[t]) begin
        e_rd[t]  = 1;
        e_row[t] = n / ifm;
        e_col[t] = n % ifm;
        if (n / ifm >= K - 1 && n % ifm >= K - 1) begin
          e_win[t + 1]       = 1;
          e_out[t + 1 + LAT] = 1;
        end
        n++;
        l = t;
      end
      t++;
    end
    for (int c = 1; c <= l + 1 + LAT; c++) e_busy[c] = 1;
    dcyc = l + 2 + LAT;
  endtask

  task automatic run_map(bit big, bit hold, bit poke,
                         output int o_done, output int o_nout);
    int dc, ndone, ocnt;
    bit st;
    int rd, wv, ov, bs, dn, rw, cl, oc;
    build(big ? BI : SI, dc);
    ndone = 0; ocnt = 0; o_done = -1; o_nout = 0;
    for (int t = 0; t <= dc; t++) begin
      st = (t == 0) || hold ||
           (poke && ((e_busy[t] && $urandom_range(4) == 0) || t == dc));
      if (big) begin b_start = st; b_ready = ir[t]; end
      else     begin s_start = st; s_ready = ir[t]; end
      @(negedge clk);
      rd = big ? int'(b_rd)   : int'(s_rd);
      wv = big ? int'(b_win)  : int'(s_win);
      ov = big ? int'(b_ov)   : int'(s_ov);
      bs = big ? int'(b_busy) : int'(s_busy);
      dn = big ? int'(b_done) : int'(s_done);
      rw = big ? int'(b_row)  : int'(s_row);
      cl = big ? int'(b_col)  : int'(s_col);
      oc = big ? int'(b_oc)   : int'(s_oc);
      check("rd_en", rd, int'(e_rd[t]));
      check("win_valid", wv, int'(e_win[t]));
      check("out_valid", ov, int'(e_out[t]));
      check("busy", bs, int'(e_busy[t]));
      check("done", dn, (t == dc) ? 1 : 0);
      if (e_rd[t]) begin
        check("row_cnt", rw, e_row[t]);
        check("col_cnt", cl, e_col[t]);
      end
      if (t >= 1) check("out_cnt", oc, ocnt);
      if (t >= 1 && e_out[t]) ocnt++;
      if (ov != 0) o_nout++;
      if (dn != 0) begin
        ndone++;
        if (o_done < 0) o_done = t;
      end
      @(posedge clk); #1;
    end
    check("done_pulses", ndone, 1);
    if (!hold) begin
      s_start = 1'b0; b_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("idle_busy", big ? int'(b_busy) : int'(s_busy), 0);
        check("idle_rd_en", big ? int'(b_rd) : int'(s_rd), 0);
        check("idle_done", big ? int'(b_done) : int'(s_done), 0);
        check("out_cnt_hold", big ? int'(b_oc) : int'(s_oc), ocnt);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic fill(int pct);
    for (int i = 0; i < MAXC; i++) ir[i] = ($urandom_range(99) < pct);
  endtask

  initial begin
    int d, n;
    #12;
    check("rst_rd_en", int'(s_rd), 0);
    check("rst_win", int'(s_win), 0);
    check("rst_out_valid", int'(s_ov), 0);
    check("rst_busy", int'(s_busy), 0);
    check("rst_done", int'(s_done), 0);
    check("rst_out_cnt", int'(s_oc), 0);
    check("rst_row", int'(s_row), 0);
    check("rst_big_oc", int'(b_oc), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill(100);
    run_map(0, 0, 0, d, n);
    check("nom_done_cycle", d, 26);
    check("nom_out_pulses", n, 4);

    fill(100);
    for (int i = 5; i <= 7; i++) ir[i] = 0;
    run_map(0, 0, 0, d, n);
    check("bubble_done_cycle", d, 29);
    check("bubble_out_pulses", n, 4);

    fill(100);
    run_map(0, 0, 1, d, n);
    check("poke_done_cycle", d, 26);
    check("poke_out_pulses", n, 4);

    for (int r = 0; r < 6; r++) begin
      fill(65);
      run_map(0, 0, r[0], d, n);
      check("rand_out_pulses", n, 4);
    end

    fill(100);
    s_start = 1'b1; s_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      s_start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", int'(s_rd), 0);
    check("mid_rst_win", int'(s_win), 0);
    check("mid_rst_out_valid", int'(s_ov), 0);
    check("mid_rst_busy", int'(s_busy), 0);
    check("mid_rst_done", int'(s_done), 0);
    check("mid_rst_out_cnt", int'(s_oc), 0);
    check("mid_rst_col", int'(s_col), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", int'(s_ov), 0);
      @(posedge clk); #1;
    end
    run_map(0, 0, 0, d, n);
    check("after_rst_done_cycle", d, 26);
    check("after_rst_out_pulses", n, 4);

    fill(100);
    run_map(0, 1, 0, d, n);
    check("b2b_first_done", d, 26);
    run_map(0, 1, 0, d, n);
    check("b2b_second_done", d, 26);
    check("b2b_second_pulses", n, 4);
    s_start = 1'b0;
    @(negedge clk);
    check("b2b_out_cnt", int'(s_oc), 4);
    @(posedge clk); #1;

    fill(100);
    run_map(1, 0, 0, d, n);
    check("big_done_cycle", d, 1034);
    check("big_out_pulses", n, 900);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Sequencer for one CNN conv unit. It walks an IFM_SIZE x IFM_SIZE input feature map in raster order and pops one pixel per cycle from upstream while data is available. It flags which pixels complete a KERNEL_SIZE x KERNEL_SIZE window, and tracks those flags through the fixed-latency conv datapath to produce an aligned out_valid. It drains the pipeline, then signals done. It sits between the line-buffer/FIFO feeding the unit and the downstream pooling/writeback stage.

Parameters:
IFM_SIZE, 32, feature-map width and height in pixels (>= KERNEL_SIZE)
KERNEL_SIZE, 3, convolution window size
PIPE_LATENCY, 8, datapath latency in cycles from win_valid to result (>= 1)
CNT_W, $clog2(IFM_SIZE), row/col counter width
OUT_W, $clog2((IFM_SIZE-KERNEL_SIZE+1)**2+1), output counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin one feature map; sampled only in IDLE
in_ready  in  1  upstream pixel available this cycle
rd_en  out  1  pop one pixel from upstream (combinational)
row_cnt  out  CNT_W  row index of the pixel being read
col_cnt  out  CNT_W  column index of the pixel being read
win_valid  out  1  registered: datapath input holds a complete window
out_valid  out  1  win_valid delayed PIPE_LATENCY cycles
out_cnt  out  OUT_W  number of out_valid pulses in the current map
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; row_cnt, col_cnt, drain_cnt and out_cnt = 0; win_valid, busy and done = 0; valid delay line cleared, so out_valid = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN. Counters and out_cnt clear on that edge. start in any other state is ignored.
- RUN: rd_en = in_ready. On rd_en, col_cnt increments. At col = IFM_SIZE-1, col wraps to 0 and row increments. When rd_en hits row = col = IFM_SIZE-1, FSM -> DRAIN and counters return to 0.
- RUN with in_ready=0: counters hold and a bubble (win_valid=0) enters the pipe. The datapath never stalls.
- win_valid(t+1) = rd_en(t) && row_cnt >= KERNEL_SIZE-1 && col_cnt >= KERNEL_SIZE-1.
- out_valid(t) = win_valid(t-PIPE_LATENCY). Total rd_en -> out_valid latency is PIPE_LATENCY+1 cycles.
- out_cnt increments on each out_valid and holds its value through DONE and into IDLE.
- DRAIN: rd_en=0. drain_cnt counts 0..PIPE_LATENCY. At PIPE_LATENCY, FSM -> DONE. If the last read is at cycle L, DRAIN covers cycles L+1..L+1+PIPE_LATENCY, the last out_valid falls at L+1+PIPE_LATENCY, and done is at L+2+PIPE_LATENCY.
- DONE: done=1 for exactly one cycle, then -> IDLE. start seen in DONE is ignored, not queued.
- Total out_valid pulses per map: (IFM_SIZE-KERNEL_SIZE+1)^2 (900 at defaults), independent of in_ready bubbles.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No residual out_valid after reset is released.

Decomposition:
- Shared package: FSM state encoding (2 bits), and the derived widths/constants CNT_W and OUT_W with the window-count function.
- Sub-module valid_delay_line: 1-bit shift register of depth PIPE_LATENCY with async active-low clear, carrying win_valid to out_valid.

Test Plan:
- IFM_SIZE=4, K=3, LAT=8; start at cycle 0, in_ready=1 -> rd_en on cycles 1..16; win_valid on 12,13,16,17; out_valid on 20,21,24,25; done at 26 only; out_cnt=4.
- Same config, in_ready=0 on cycles 5..7 -> every rd_en/win_valid/out_valid/done cycle shifts +3; still exactly 4 out_valid pulses.
- Defaults (32,3,8), in_ready=1 -> 1024 rd_en pulses, 900 out_valid pulses, done exactly 1+1024+9 = 1034 cycles after the start edge.
- Pulse start during RUN and during DONE -> no restart, no counter disturbance, single done per map.
- Assert reset on cycle 14 of the first scenario -> all outputs 0 immediately; no out_valid for 20 cycles after release; a new start then gives the nominal sequence.
- Back-to-back maps with start held high -> second map begins the cycle after returning to IDLE; out_cnt reset to 0, then reaches 4 again.
